// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: d = a - b - bin, one 4-bit slice per clock, LSB first.
// Optional ovf/zero flag logic is enabled by defining NSUB_FLAGS_EN.
module nibble_serial_sub #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2**N-1:0] a,
  input  logic [2**N-1:0] b,
  input  logic           bin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2**N-1:0] d,
  output logic           bout,
  output logic           ovf,
  output logic           zero
);

  localparam int W   = 2**N;
  localparam int NIB = W / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    a_q, b_q, res_q, res_d;
  logic            borrow_q, bout_q, in_ready_q, out_valid_q;

  logic [IW+1:0]   sh_s;
  logic [W-1:0]    a_sh_s, b_sh_s;
  logic [3:0]      a_nib_s, b_nib_s;
  logic [4:0]      sum5_s;
  logic            last_s;

  // Current slice: borrow-subtract expressed as a + ~b + ~borrow.
  always_comb begin
    sh_s    = {idx_q, 2'b00};
    a_sh_s  = a_q >> sh_s;
    b_sh_s  = b_q >> sh_s;
    a_nib_s = a_sh_s[3:0];
    b_nib_s = b_sh_s[3:0];
    sum5_s  = {1'b0, a_nib_s} + {1'b0, ~b_nib_s} + {4'b0000, ~borrow_q};
    res_d   = (res_q & ~(W'(4'hF) << sh_s)) | (W'(sum5_s[3:0]) << sh_s);
    last_s  = (idx_q == IW'(NIB - 1));
  end

`ifdef NSUB_FLAGS_EN
  logic ovf_q, zero_q, zacc_q;
  logic nib_zero_s, ovf_d;

  // Flag terms for the slice in flight; ovf only matters on the MSB slice.
  always_comb begin
    nib_zero_s = (sum5_s[3:0] == 4'h0);
    ovf_d      = (a_q[W-1] != b_q[W-1]) && (sum5_s[3] != a_q[W-1]);
  end
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef NSUB_FLAGS_EN
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      zacc_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            borrow_q   <= bin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
`ifdef NSUB_FLAGS_EN
            zacc_q     <= 1'b1;
`endif
          end
        end
        S_RUN: begin
          res_q    <= res_d;
          borrow_q <= ~sum5_s[4];
`ifdef NSUB_FLAGS_EN
          zacc_q   <= zacc_q & nib_zero_s;
`endif
          if (last_s) begin
            bout_q      <= ~sum5_s[4];
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
`ifdef NSUB_FLAGS_EN
            ovf_q       <= ovf_d;
            zero_q      <= zacc_q & nib_zero_s;
`endif
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign d         = res_q;
  assign bout      = bout_q;
`ifdef NSUB_FLAGS_EN
  assign ovf       = ovf_q;
  assign zero      = zero_q;
`else
  assign ovf       = 1'b0;
  assign zero      = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed bench for nibble_serial_sub: N=3 and N=4 instances on one clock.
module tb_nibble_serial_sub;

`ifdef NSUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid3 = 1'b0, in_ready3, bin3 = 1'b0, out_valid3, out_ready3 = 1'b0;
  logic        bout3, ovf3, zero3;
  logic [7:0]  a3 = '0, b3 = '0, d3;
  logic        in_valid4 = 1'b0, in_ready4, bin4 = 1'b0, out_valid4, out_ready4 = 1'b0;
  logic        bout4, ovf4, zero4;
  logic [15:0] a4 = '0, b4 = '0, d4;

  nibble_serial_sub #(.N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .bin(bin3), .out_valid(out_valid3), .out_ready(out_ready3),
    .d(d3), .bout(bout3), .ovf(ovf3), .zero(zero3));

  nibble_serial_sub #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .d(d4), .bout(bout4), .ovf(ovf4), .zero(zero4));

  typedef struct {
    int          w;
    logic [15:0] a, b;
    logic        bin;
    logic [15:0] d;
    logic        bout, ovf, zero;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic bi, input logic r);
    if (w == 3) begin
      in_valid3 = v; a3 = a[7:0]; b3 = b[7:0]; bin3 = bi; out_ready3 = r;
    end else begin
      in_valid4 = v; a4 = a; b4 = b; bin4 = bi; out_ready4 = r;
    end
  endtask

  task automatic sample(input int w, output logic ir, output logic ov, output logic [15:0] dd,
                        output logic bo, output logic of, output logic z);
    if (w == 3) begin
      ir = in_ready3; ov = out_valid3; dd = {8'h00, d3}; bo = bout3; of = ovf3; z = zero3;
    end else begin
      ir = in_ready4; ov = out_valid4; dd = d4; bo = bout4; of = ovf4; z = zero4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, scramble inputs during RUN, check latency/result, then drain.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    logic ir, ov, bo, of, z;
    logic [15:0] dd;
    sample(v.w, ir, ov, dd, bo, of, z);
    chk({tag, " in_ready_idle"}, {31'd0, ir}, 32'd1);
    drive(v.w, 1'b1, v.a, v.b, v.bin, 1'b0);
    step();
    drive(v.w, 1'b0, 16'hDEAD, 16'hBEEF, ~v.bin, 1'b0);
    cyc = 0;
    sample(v.w, ir, ov, dd, bo, of, z);
    while (!ov && cyc < 40) begin
      step();
      cyc++;
      sample(v.w, ir, ov, dd, bo, of, z);
    end
    chk({tag, " latency"}, cyc, (v.w == 3) ? 32'd2 : 32'd4);
    chk({tag, " d"}, {16'd0, dd}, {16'd0, v.d});
    chk({tag, " bout"}, {31'd0, bo}, {31'd0, v.bout});
    chk({tag, " ovf"}, {31'd0, of}, {31'd0, v.ovf & FLAGS});
    chk({tag, " zero"}, {31'd0, z}, {31'd0, v.zero & FLAGS});
    drive(v.w, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step();
    drive(v.w, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    sample(v.w, ir, ov, dd, bo, of, z);
    chk({tag, " out_valid_drop"}, {31'd0, ov}, 32'd0);
    chk({tag, " d_hold"}, {16'd0, dd}, {16'd0, v.d});
  endtask

  vec_t vecs[10];

  initial begin
    logic ir, ov, bo, of, z;
    logic [15:0] dd;
    int acc1, acc2, nres;
    logic rdy;
    logic [15:0] res[4];

    vecs[0] = '{3, 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3, 16'h0000, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{3, 16'h00FF, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{3, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{3, 16'h005A, 16'h005A, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{3, 16'h007F, 16'h00FF, 1'b0, 16'h0080, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{4, 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{4, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{4, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{4, 16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

    #12;
    for (int w = 3; w <= 4; w++) begin
      sample(w, ir, ov, dd, bo, of, z);
      chk($sformatf("reset%0d in_ready", w), {31'd0, ir}, 32'd1);
      chk($sformatf("reset%0d out_valid", w), {31'd0, ov}, 32'd0);
      chk($sformatf("reset%0d d", w), {16'd0, dd}, 32'd0);
      chk($sformatf("reset%0d flags", w), {29'd0, bo, of, z}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held 5 cycles while in_valid pulses are ignored.
    drive(3, 1'b1, 16'h0010, 16'h0001, 1'b0, 1'b0);
    step();
    drive(3, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      drive(3, i[0], 16'h0033, 16'h0011, 1'b1, 1'b0);
      step();
      chk($sformatf("bp%0d out_valid", i), {31'd0, out_valid3}, 32'd1);
      chk($sformatf("bp%0d d", i), {24'd0, d3}, 32'h0F);
      chk($sformatf("bp%0d in_ready", i), {31'd0, in_ready3}, 32'd0);
    end
    drive(3, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step();
    drive(3, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("bp release out_valid", {31'd0, out_valid3}, 32'd0);
    chk("bp release in_ready", {31'd0, in_ready3}, 32'd1);
    chk("bp release d", {24'd0, d3}, 32'h0F);

    // Back-to-back with in_valid and out_ready held high.
    acc1 = -1; acc2 = -1; nres = 0;
    drive(4, 1'b1, 16'h1234, 16'h0235, 1'b0, 1'b1);
    for (int c = 0; c < 30; c++) begin
      rdy = in_ready4;
      step();
      if (rdy && in_valid4) begin
        if (acc1 < 0) begin
          acc1 = c;
          drive(4, 1'b1, 16'h5000, 16'h0001, 1'b0, 1'b1);
        end else if (acc2 < 0) begin
          acc2 = c;
          drive(4, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        end
      end
      if (out_valid4 && nres < 4) begin
        res[nres] = d4;
        nres++;
      end
    end
    drive(4, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("b2b interval", acc2 - acc1, 32'd6);
    chk("b2b result count", nres, 32'd2);
    chk("b2b first d", {16'd0, res[0]}, 32'h0FFF);
    chk("b2b second d", {16'd0, res[1]}, 32'h4FFF);

    // Reset during RUN with idx=2, then a fresh operation.
    drive(4, 1'b1, 16'h1234, 16'h0235, 1'b0, 1'b0);
    step();
    drive(4, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_run in_ready", {31'd0, in_ready4}, 32'd1);
    chk("rst_run out_valid", {31'd0, out_valid4}, 32'd0);
    chk("rst_run d", {16'd0, d4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_vec('{4, 16'h4321, 16'h0021, 1'b0, 16'h4300, 1'b0, 1'b0, 1'b0}, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
